// File: rtl/main_memory_pkg.sv
// Shared types and constants for the MIC-1 main memory: port FSM states,
// the captured port-A command, and the byte-lane select helper.
package main_memory_pkg;

    localparam int WORD_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int LANES           = 4;
    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } port_state_e;

    // Port A command as captured on accept
    typedef struct packed {
        logic              we;
        logic [LANES-1:0]  be;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } port_cmd_t;

    // Little-endian byte pick: lane 0 is bits [7:0]
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane);
        return word[lane*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Per-port req/ack handshake: IDLE -> BUSY -> DONE -> (IDLE | BUSY).
// Captures the command on accept, counts WAIT_STATES busy cycles, then
// flags the edge at which the array access happens and pulses ack in DONE.
module mem_port_fsm
    import main_memory_pkg::*;
#(
    parameter int  WAIT_STATES = 0,
    parameter type cmd_t       = port_cmd_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  cmd_t cmd_in,
    output cmd_t cmd,
    output logic access,
    output logic ack
);

    localparam logic [CNT_W-1:0] WS_LD = CNT_W'(WAIT_STATES);

    port_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             capture;

    // New commands are only taken when the port is idle or finishing
    assign capture = req && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = req ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: access marks the edge that touches the array, ack is the DONE cycle
    always_comb begin
        access = (state == BUSY) && (cnt == '0);
        ack    = (state == DONE);
    end

    // Command capture and wait-state countdown
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            cmd <= '0;
        end else if (capture) begin
            cnt <= WS_LD;
            cmd <= cmd_in;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/main_memory_hs.sv
// MIC-1 main memory with programmable wait states and a req/ack handshake
// per port. Port A: 32-bit word read/write with byte enables (MAR/MDR).
// Port B: byte-addressed read-only fetch (PC/MBR).
// Build option MEM_BOUNDS_CHECK_EN: word index >= DEPTH suppresses writes,
// reads return 0 and err pulses with the offending ack. Without it the
// word index wraps to ADDR_W bits and err is tied low.
module main_memory_hs
    import main_memory_pkg::*;
#(
    parameter int    DEPTH       = 512,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_F      = "",
    parameter int    INIT_WORDS  = DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [LANES-1:0]  a_be,
    input  logic [WORD_W-1:0] a_addr,
    input  logic [WORD_W-1:0] a_wdata,
    output logic [WORD_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [WORD_W-1:0] b_addr,
    output logic [BYTE_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              err
);

    localparam int ADDR_W = $clog2(DEPTH);

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES ||
        INIT_WORDS > DEPTH || (INIT_F != "" && INIT_WORDS <= 0)) begin : g_bad_cfg
        $error("main_memory_hs: unsupported parameter combination");
    end

    port_cmd_t         a_cmd_in, a_cmd;
    logic [WORD_W-1:0] b_cmd;
    logic              a_acc, b_acc;
    logic [ADDR_W-1:0] a_idx, b_idx;
    logic [WORD_W-1:0] b_word;
    logic [1:0]        b_lane;
    logic              a_oob, b_oob;
    logic              a_wr;

    logic [WORD_W-1:0] mem [DEPTH];

    assign a_cmd_in = '{we: a_we, be: a_be, addr: a_addr, wdata: a_wdata};

    mem_port_fsm #(
        .WAIT_STATES (WAIT_STATES),
        .cmd_t       (port_cmd_t)
    ) u_port_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (a_req),
        .cmd_in (a_cmd_in),
        .cmd    (a_cmd),
        .access (a_acc),
        .ack    (a_ack)
    );

    // Port B only needs its byte address
    mem_port_fsm #(
        .WAIT_STATES (WAIT_STATES),
        .cmd_t       (logic [WORD_W-1:0])
    ) u_port_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (b_req),
        .cmd_in (b_addr),
        .cmd    (b_cmd),
        .access (b_acc),
        .ack    (b_ack)
    );

    assign a_idx  = a_cmd.addr[ADDR_W-1:0];
    assign b_word = {2'b00, b_cmd[WORD_W-1:2]};
    assign b_idx  = b_word[ADDR_W-1:0];
    assign b_lane = b_cmd[1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    assign a_oob = (a_cmd.addr >= WORD_W'(DEPTH));
    assign b_oob = (b_word     >= WORD_W'(DEPTH));

    // err lines up with the DONE cycle of whichever port went out of range
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else        err <= (a_acc && a_oob) || (b_acc && b_oob);
    end
`else
    logic unused_addr_hi;
    assign a_oob          = 1'b0;
    assign b_oob          = 1'b0;
    assign err            = 1'b0;
    assign unused_addr_hi = ^{a_cmd.addr[WORD_W-1:ADDR_W], b_word[WORD_W-1:ADDR_W]};
`endif

    // rst_n gate keeps an access landing on a reset edge from committing
    assign a_wr = rst_n && a_acc && a_cmd.we && !a_oob;

    // Byte-lane write; a_be of zero is a legal no-op
    always_ff @(posedge clk) begin
        if (a_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_cmd.be[i]) mem[a_idx][i*BYTE_W +: BYTE_W] <= a_cmd.wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Port A read data, held across writes and idle cycles
    always_ff @(posedge clk) begin
        if (!rst_n)                    a_rdata <= '0;
        else if (a_acc && !a_cmd.we)   a_rdata <= a_oob ? '0 : mem[a_idx];
    end

    // Port B fetch; sees pre-write data on a same-edge port A write
    always_ff @(posedge clk) begin
        if (!rst_n)     b_rdata <= '0;
        else if (b_acc) b_rdata <= b_oob ? '0 : byte_sel(mem[b_idx], b_lane);
    end

endmodule

// File: tb/tb_main_memory_hs.sv
// Directed + randomized bench for main_memory_hs against a word-array model.
module tb_main_memory_hs;

    localparam int DEPTH = 512;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [3:0]  a_be = '0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [31:0] a_rdata;
    logic        a_ack;
    logic        b_req = 1'b0;
    logic [31:0] b_addr = '0;
    logic [7:0]  b_rdata;
    logic        b_ack, err;

    always #5 clk = ~clk;

    main_memory_hs #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS),
        .INIT_F      (""),
        .INIT_WORDS  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_be    (a_be),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .a_ack   (a_ack),
        .b_req   (b_req),
        .b_addr  (b_addr),
        .b_rdata (b_rdata),
        .b_ack   (b_ack),
        .err     (err)
    );

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] m_ra = '0;
    logic [7:0]  m_rb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] w);
`ifdef MEM_BOUNDS_CHECK_EN
        return w < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    // One transaction on A and/or B issued in the same cycle; checks latency,
    // read data, err and ack hygiene, then applies the write to the model.
    task automatic run(input bit a_en, input bit we, input logic [3:0] be,
                       input logic [31:0] aa, input logic [31:0] wd,
                       input bit b_en, input logic [31:0] ba);
        logic [31:0] exp_ra, bw, mask;
        logic [7:0]  exp_rb;
        logic [1:0]  lane;
        bit          a_in, b_in, got_a, got_b, oob_any;
        int          n;
        exp_ra = m_ra;
        exp_rb = m_rb;
        a_in   = in_rng(aa);
        bw     = ba >> 2;
        lane   = ba[1:0];
        b_in   = in_rng(bw);
        if (a_en && !we) exp_ra = a_in ? ref_mem[aa % DEPTH] : 32'h0;
        if (b_en) exp_rb = b_in ? 8'((ref_mem[bw % DEPTH] >> (8 * lane)) & 32'hFF) : 8'h0;
        oob_any = (a_en && !a_in) || (b_en && !b_in);
        tick();
        a_req = a_en; a_we = we; a_be = be; a_addr = aa; a_wdata = wd;
        b_req = b_en; b_addr = ba;
        n = 0; got_a = !a_en; got_b = !b_en;
        while (!(got_a && got_b) && n < 40) begin
            tick();
            n++;
            if (n == 1) begin
                a_req = 1'b0; b_req = 1'b0;
                a_addr = $urandom; a_wdata = $urandom; a_be = 4'($urandom); b_addr = $urandom;
            end
            if (a_ack) begin
                chk("a_lat", n, WS + 2);
                chk("a_rdata", a_rdata, exp_ra);
                got_a = 1'b1;
            end
            if (b_ack) begin
                chk("b_lat", n, WS + 2);
                chk("b_rdata", {24'h0, b_rdata}, {24'h0, exp_rb});
                got_b = 1'b1;
            end
            if (!a_en) chk("a_spurious", {31'h0, a_ack}, 32'h0);
            if (!b_en) chk("b_spurious", {31'h0, b_ack}, 32'h0);
            chk("err", {31'h0, err}, {31'h0, (n == WS + 2) && oob_any});
        end
        if (!(got_a && got_b)) chk("ack_timeout", n, WS + 2);
        if (a_en && we && a_in) begin
            mask = '0;
            for (int i = 0; i < 4; i++) if (be[i]) mask |= 32'hFF << (8 * i);
            ref_mem[aa % DEPTH] = (ref_mem[aa % DEPTH] & ~mask) | (wd & mask);
        end
        m_ra = exp_ra;
        m_rb = exp_rb;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old88, word20;
        int          n;
        bit          seen;

        // Reset state
        repeat (3) tick();
        chk("rst_a_ack", {31'h0, a_ack}, 32'h0);
        chk("rst_b_ack", {31'h0, b_ack}, 32'h0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", {24'h0, b_rdata}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Known contents for the words the bench touches; every byte nonzero
        for (int w = 0; w < 96; w++) run(1, 1, 4'hF, w, $urandom | 32'h01010101, 0, 0);

        // Full-word write then read
        run(1, 1, 4'hF, 5, 32'hDEADBEEF, 0, 0);
        run(1, 0, 4'h0, 5, 32'h0, 0, 0);
        chk("rd_deadbeef", a_rdata, 32'hDEADBEEF);

        // Partial byte-lane write
        run(1, 1, 4'hF, 7, 32'hAAAAAAAA, 0, 0);
        run(1, 1, 4'b0101, 7, 32'h11223344, 0, 0);
        run(1, 0, 4'h0, 7, 32'h0, 0, 0);
        chk("rd_lanes", a_rdata, 32'hAA22AA44);

        // a_be=0 write is a no-op that still acks
        run(1, 1, 4'h0, 7, 32'h55555555, 0, 0);
        run(1, 0, 4'h0, 7, 32'h0, 0, 0);

        // Back-to-back byte fetches of word 3
        run(1, 1, 4'hF, 3, 32'h44332211, 0, 0);
        tick();
        b_req = 1'b1; b_addr = 12;
        for (int i = 0; i < 4; i++) begin
            n = 0; seen = 1'b0;
            while (!seen && n < 40) begin
                tick();
                n++;
                if (b_ack) seen = 1'b1;
            end
            chk($sformatf("b2b_lat%0d", i), n, WS + 2);
            chk($sformatf("b2b_byte%0d", i), {24'h0, b_rdata}, 32'h11 * (i + 1));
            if (i < 3) b_addr = 12 + i + 1;
            else       b_req = 1'b0;
        end
        m_rb = 8'h44;

        // Same-edge collision: B sees pre-write data, then the new value
        run(1, 1, 4'hF, 9, 32'h000000FF, 0, 0);
        run(1, 1, 4'hF, 9, 32'h0, 1, 36);
        chk("coll_pre", {24'h0, b_rdata}, 32'hFF);
        run(0, 0, 4'h0, 0, 0, 1, 36);
        chk("coll_post", {24'h0, b_rdata}, 32'h00);

        // Out-of-range word 600 (aliases word 88 when wrapping)
        old88 = ref_mem[88];
        run(1, 1, 4'hF, 600, 32'h600DF00D, 0, 0);
        run(1, 0, 4'h0, 88, 32'h0, 0, 0);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("oob_word88", a_rdata, old88);
        run(1, 0, 4'h0, 600, 32'h0, 0, 0);
        chk("oob_read0", a_rdata, 32'h0);
`else
        chk("wrap_word88", a_rdata, 32'h600DF00D);
        chk("wrap_changed", {31'h0, a_rdata != old88}, {31'h0, 32'h600DF00D != old88});
`endif

        // Reset during a BUSY write: no ack, no commit, outputs cleared
        run(1, 0, 4'h0, 1, 32'h0, 1, 4);
        word20 = ref_mem[20];
        tick();
        a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 20; a_wdata = ~word20;
        tick();
        a_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_a_rdata", a_rdata, 32'h0);
        chk("mid_rst_b_rdata", {24'h0, b_rdata}, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        m_ra = '0;
        m_rb = '0;
        for (int i = 0; i < 8; i++) begin
            chk("mid_rst_no_ack", {30'h0, a_ack, b_ack}, 32'h0);
            tick();
        end
        run(1, 0, 4'h0, 20, 32'h0, 0, 0);
        chk("mid_rst_word20", a_rdata, word20);

        // Randomized traffic on both ports
        for (int k = 0; k < 250; k++) begin
            bit          ae, be_n, we;
            logic [31:0] aa;
            ae   = 1'($urandom_range(0, 1));
            be_n = 1'($urandom_range(0, 1));
            if (!ae && !be_n) ae = 1'b1;
            we   = 1'($urandom_range(0, 1));
            aa   = ($urandom_range(0, 3) == 0) ? 32'(512 + $urandom_range(0, 95))
                                               : 32'($urandom_range(0, 95));
            run(ae, we, 4'($urandom_range(0, 15)), aa, $urandom, be_n, 32'($urandom_range(0, 383)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
